// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage load/store initiator.
package mem_access_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] wdata,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              is_signed,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    byte_v    = word[8*lane +: 8];
    half_v    = word[16*lane[1] +: 16];
    load_data = word;
    merged    = wdata;
    case (size)
      SZ_B: begin
        load_data             = {{24{is_signed & byte_v[7]}}, byte_v};
        merged                = word;
        merged[8*lane +: 8]   = wdata[7:0];
      end
      SZ_H: begin
        load_data               = {{16{is_signed & half_v[15]}}, half_v};
        merged                  = word;
        merged[16*lane[1] +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: request latch, 4-state FSM, ReadData capture and
// read-modify-write for sub-word stores against a single-ported data memory.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [WORD_W-1:0] addr,
  output logic [WORD_W-1:0] WriteData,
  input  logic [WORD_W-1:0] ReadData
);

  localparam logic [WORD_W:0] ADDR_LIMIT = (WORD_W+1)'(MEM_WORDS) << 2;

  state_t            state_q, state_d;
  logic              lat_write, lat_signed, lat_err;
  logic [1:0]        lat_size;
  logic [WORD_W-1:0] lat_addr, lat_wdata, rdata_q;
  logic              req_bad;
  logic [WORD_W-1:0] load_data, merged;

  // Request legality is judged on the live request only in IDLE; the verdict is latched.
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      SZ_B:    req_bad = 1'b0;
      SZ_H:    req_bad = req_addr[0];
      SZ_W:    req_bad = |req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
    if ({1'b0, req_addr} >= ADDR_LIMIT) req_bad = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (req_bad)                       state_d = RESP;
        else if (req_write && req_size == SZ_W) state_d = WR;
        else                               state_d = RD;
      end
      RD:      state_d = lat_write ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_write  <= 1'b0;
      lat_signed <= 1'b0;
      lat_err    <= 1'b0;
      lat_size   <= SZ_B;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        lat_write  <= req_write;
        lat_signed <= req_signed;
        lat_err    <= req_bad;
        lat_size   <= req_size;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
      end
      if (state_q == RD) rdata_q <= ReadData;
    end
  end

  mem_lane_align u_align (
    .word      (rdata_q),
    .wdata     (lat_wdata),
    .lane      (lat_addr[1:0]),
    .size      (lat_size),
    .is_signed (lat_signed),
    .load_data (load_data),
    .merged    (merged)
  );

  // Memory-side outputs are decoded from registers only; nothing here looks at req_*.
  assign req_ready  = (state_q == IDLE);
  assign MemRead    = (state_q == RD);
  assign MemWrite   = (state_q == WR);
  assign addr       = {lat_addr[WORD_W-1:2], 2'b00};
  assign WriteData  = (state_q != WR) ? '0 : (lat_size == SZ_W) ? lat_wdata : merged;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & lat_err;
  assign resp_rdata = (resp_valid && !lat_write && !lat_err) ? load_data : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: behavioural memory, directed scenarios and random requests
// compared against an arithmetic reference model of loads, stores and timing.
module tb_mem_access_unit;

  localparam int MEM_WORDS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, MemRead, MemWrite;
  logic [31:0] resp_rdata, addr, WriteData, ReadData;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  logic [31:0] tb_mem  [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .WriteData(WriteData), .ReadData(ReadData)
  );

  // Data memory: asynchronous read, write captured on the clock edge.
  assign ReadData = (MemRead && addr[31:7] == 25'd0) ? tb_mem[addr[6:2]] : 32'h0;
  always @(posedge clk) if (MemWrite && addr[31:7] == 25'd0) tb_mem[addr[6:2]] <= WriteData;
  always @(negedge clk) if (!reset && MemRead && MemWrite) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_err(input int size, input logic [31:0] a);
    return size == 3 || (size == 1 && a[0]) || (size == 2 && a[1:0] != 0) ||
           a >= 32'(MEM_WORDS * 4);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input int size, input bit sgn);
    int v;
    if (size == 0) begin
      v = int'((w >> (8 * (a % 4))) & 32'hFF);
      if (sgn && v >= 128) v = v - 256;
    end else if (size == 1) begin
      v = int'((w >> (16 * ((a / 2) % 2))) & 32'hFFFF);
      if (sgn && v >= 32768) v = v - 65536;
    end else begin
      v = int'(w);
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [31:0] a, input int size);
    logic [31:0] mask;
    int sh;
    if (size == 2) return d;
    sh   = (size == 0) ? 8 * int'(a % 4) : 16 * int'((a / 2) % 2);
    mask = ((size == 0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // ---------------- request driver / observer ----------------
  task automatic do_req(input bit wr, input int size, input bit sgn,
                        input logic [31:0] a, input logic [31:0] d,
                        output int rd_cyc, output int wr_cyc, output int resp_cyc,
                        output int rd_cnt, output int wr_cnt,
                        output logic [31:0] wdat, output logic [31:0] saddr,
                        output logic [31:0] rdata, output logic err);
    rd_cyc = 0; wr_cyc = 0; resp_cyc = 0; rd_cnt = 0; wr_cnt = 0;
    wdat = 0; saddr = 0; rdata = 0; err = 0;
    @(negedge clk);
    req_write = wr; req_size = 2'(size); req_signed = sgn;
    req_addr = a; req_wdata = d; req_valid = 1'b1;
    check("ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (MemRead) begin
        rd_cnt++;
        if (rd_cyc == 0) rd_cyc = cyc;
        saddr = addr;
      end
      if (MemWrite) begin
        wr_cnt++;
        if (wr_cyc == 0) wr_cyc = cyc;
        wdat = WriteData; saddr = addr;
      end
      if (resp_valid) begin
        resp_cyc = cyc; rdata = resp_rdata; err = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    if (resp_cyc != 0) @(posedge clk);
  endtask

  task automatic run_and_check(input bit wr, input int size, input bit sgn,
                               input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] o_rdata, output logic [31:0] o_wdata);
    int rd_cyc, wr_cyc, resp_cyc, rd_cnt, wr_cnt;
    int e_rd, e_wr, e_resp;
    logic [31:0] saddr, e_word, e_rdata;
    logic err;
    bit e_err;
    e_err  = model_err(size, a);
    e_rd   = (e_err || (wr && size == 2)) ? 0 : 1;
    e_wr   = (!e_err && wr) ? e_rd + 1 : 0;
    e_resp = e_err ? 1 : (e_wr != 0 ? e_wr + 1 : e_rd + 1);
    e_word  = e_err ? 32'h0 : model_store(ref_mem[a[6:2]], d, a, size);
    e_rdata = (e_err || wr) ? 32'h0 : model_load(ref_mem[a[6:2]], a, size, sgn);
    do_req(wr, size, sgn, a, d, rd_cyc, wr_cyc, resp_cyc, rd_cnt, wr_cnt,
           o_wdata, saddr, o_rdata, err);
    check("resp_cycle",  32'(resp_cyc), 32'(e_resp));
    check("read_cycle",  32'(rd_cyc),   32'(e_rd));
    check("write_cycle", 32'(wr_cyc),   32'(e_wr));
    check("read_pulses", 32'(rd_cnt),   32'(e_rd != 0));
    check("write_pulses",32'(wr_cnt),   32'(e_wr != 0));
    check("resp_err",    32'(err),      32'(e_err));
    check("resp_rdata",  o_rdata,       e_rdata);
    if (e_wr != 0) check("write_data", o_wdata, e_word);
    if (e_rd != 0 || e_wr != 0) check("strobe_addr", saddr, {a[31:2], 2'b00});
    if (!e_err && wr) ref_mem[a[6:2]] = e_word;
  endtask

  initial begin
    logic [31:0] r, w;
    int sz;
    logic [31:0] a;
    bit rd_seen [6];
    bit rv_seen [6];
    logic [31:0] rdat_seen [6];
    bit rdy3;
    int late_wr;

    for (int i = 0; i < MEM_WORDS; i++) begin
      tb_mem[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  32'(req_ready),  32'd1);
    check("rst_resp",   32'(resp_valid), 32'd0);
    check("rst_err",    32'(resp_err),   32'd0);
    check("rst_rdata",  resp_rdata,      32'd0);
    check("rst_memrd",  32'(MemRead),    32'd0);
    check("rst_memwr",  32'(MemWrite),   32'd0);
    check("rst_addr",   addr,            32'd0);
    check("rst_wdata",  WriteData,       32'd0);
    @(negedge clk); reset = 1'b0;

    // Word store then load
    run_and_check(1, 2, 0, 32'h10, 32'hDEADBEEF, r, w);
    check("tp_store_wdata", w, 32'hDEADBEEF);
    run_and_check(0, 2, 0, 32'h10, 32'h0, r, w);
    check("tp_load_word", r, 32'hDEADBEEF);

    // Sign/zero extension of sub-word loads
    run_and_check(1, 2, 0, 32'h04, 32'h80FF7F01, r, w);
    run_and_check(0, 0, 1, 32'h06, 32'h0, r, w);
    check("tp_lb_signed", r, 32'hFFFFFFFF);
    run_and_check(0, 0, 0, 32'h07, 32'h0, r, w);
    check("tp_lbu", r, 32'h00000080);
    run_and_check(0, 1, 1, 32'h04, 32'h0, r, w);
    check("tp_lh_signed", r, 32'h00007F01);

    // Byte store read-modify-write
    run_and_check(1, 2, 0, 32'h08, 32'h11223344, r, w);
    run_and_check(1, 0, 0, 32'h09, 32'h000000AA, r, w);
    check("tp_sb_merge", w, 32'h1122AA44);

    // Error cases
    run_and_check(0, 1, 0, 32'h03, 32'h0, r, w);
    run_and_check(1, 2, 0, 32'h80, 32'h12345678, r, w);
    run_and_check(0, 3, 0, 32'h00, 32'h0, r, w);

    // Back-to-back word loads with req_valid held high
    @(negedge clk);
    req_write = 0; req_size = 2'b10; req_signed = 0; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    rdy3 = 0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      rd_seen[cyc] = MemRead; rv_seen[cyc] = resp_valid; rdat_seen[cyc] = resp_rdata;
      if (cyc == 3) rdy3 = req_ready;
      if (cyc == 5) req_valid = 1'b0;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      check("b2b_memread", 32'(rd_seen[cyc]), 32'(cyc % 3 == 1));
      check("b2b_resp",    32'(rv_seen[cyc]), 32'(cyc % 3 == 2));
    end
    check("b2b_ready_c3", 32'(rdy3), 32'd1);
    check("b2b_rdata1", rdat_seen[2], ref_mem[4]);
    check("b2b_rdata2", rdat_seen[5], ref_mem[4]);

    // Reset while a half store sits in its read phase
    @(negedge clk);
    req_write = 1; req_size = 2'b01; req_signed = 0; req_addr = 32'h0A;
    req_wdata = 32'h0000BEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_rd", 32'(MemRead), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_memwr", 32'(MemWrite),  32'd0);
    check("rst_mid_memrd", 32'(MemRead),   32'd0);
    check("rst_mid_addr",  addr,           32'd0);
    reset = 1'b0;
    late_wr = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (MemWrite) late_wr++;
    end
    check("rst_mid_no_write", 32'(late_wr), 32'd0);
    run_and_check(0, 2, 0, 32'h08, 32'h0, r, w);
    check("rst_mid_mem", r, 32'h1122AA44);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, MEM_WORDS * 4 + 15));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      run_and_check(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                    a, $urandom, r, w);
    end

    for (int i = 0; i < MEM_WORDS; i++) check("final_mem", tb_mem[i], ref_mem[i]);
    check("strobe_overlap", 32'(overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator for the MEM stage: accepts one byte, halfword or word access per request from the pipeline and drives the single-ported data memory's `addr`, `MemRead`, `MemWrite` and `WriteData` lines, capturing `ReadData`. Sub-word stores use a read-modify-write sequence; sub-word loads are lane-extracted and sign- or zero-extended. The unit sits between pipeline control and the data memory and provides a stall/handshake so the pipeline holds while an access is in flight.

## Interface
- `MEM_WORDS`, 32: memory depth in words; byte addresses ≥ `MEM_WORDS*4` are rejected.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is illegal and flagged as an error.
- `req_signed` in 1: sign-extend loads.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load result; 0 for stores and errors.
- `resp_err` out 1: misaligned, out-of-range or illegal size; valid with `resp_valid`.
- `MemRead` out 1: memory read strobe.
- `MemWrite` out 1: memory write strobe.
- `addr` out 32: word-aligned byte address, `{req_addr[31:2],2'b00}`.
- `WriteData` out 32: full word written to memory.
- `ReadData` in 32: memory read word.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: `req_ready`=1. On `req_valid` the unit latches all `req_*` fields and moves to the next state.
  - Error (size 11; half with `addr[0]`=1; word with `addr[1:0]`≠0; out of range) → RESP with err=1. No strobe is issued.
  - Load, or byte/half store → RD.
  - Word store → WR.
- RD: `MemRead`=1 for exactly one cycle. `ReadData` is registered at the end of that cycle.
  - Load → RESP.
  - Sub-word store → WR.
- WR: `MemWrite`=1 for exactly one cycle. `WriteData` is:
  - the latched `req_wdata` for a word store, or
  - the captured word with the addressed lane replaced, for byte/half stores.
- RESP: `resp_valid`=1 for one cycle, then → IDLE.
- Lane selection is little-endian:
  - byte lane = `addr[1:0]`, bits `[8*k+7:8*k]`.
  - half lane = `addr[1]`, bits `[16*h+15:16*h]`.
- Load extension: replicate the lane MSB when `req_signed`=1, else zero-fill. Word loads are passed through unchanged.
- `MemRead` and `MemWrite` are never high in the same cycle. Each is high for one cycle per access.
- At least one cycle with both strobes low separates consecutive accesses of the same kind. The memory is change-sensitive, so this separation is mandatory. It is guaranteed because RESP and IDLE always come between requests.
- Latched request fields do not change from acceptance until RESP.

## Timing
- Reset: when `reset` is high at a rising edge, state → IDLE. All outputs are 0 except `req_ready`=1. This holds from that edge on.
- Reset in RD of a read-modify-write: no write is issued.
- Reset in WR: the strobe drops at that edge. The memory contents are then whatever the memory captured.
- Latency, counted from the acceptance edge (cycle 0):
  - Load: `MemRead` in cycle 1, `resp_valid` in cycle 2.
  - Word store: `MemWrite` in cycle 1, `resp_valid` in cycle 2.
  - Sub-word store: `MemRead` in cycle 1, `MemWrite` in cycle 2, `resp_valid` in cycle 3.
  - Error: `resp_valid` in cycle 1.
- Throughput:
  - one load or word store per 3 cycles;
  - one sub-word store per 4 cycles;
  - one error per 2 cycles.
- `req_valid` held high through RESP is not accepted until the next IDLE cycle.
- Strobes, `addr` and `WriteData` are registered outputs or decoded from registers only. There is no combinational path from `req_*` to them.

## Structure
- Package `mem_access_pkg`:
  - size codes `SZ_B`, `SZ_H`, `SZ_W`;
  - state encoding;
  - `WORD_W`=32.
- Sub-module `mem_lane_align`, purely combinational:
  - extract+extend(word, lane, size, signed) → 32-bit result;
  - merge(word, wdata, lane, size) → 32-bit word.
- Top level contains the FSM, the request latch and the `ReadData` capture register.

## Test plan
- Word store then load: store 0xDEADBEEF to 0x10 → `MemWrite` in cycle 1 with `addr`=0x10 and `WriteData`=0xDEADBEEF. A word load from 0x10 then returns `resp_rdata`=0xDEADBEEF with err=0.
- Signed byte load: word 0x80FF7F01 stored at 0x04.
  - Signed byte load at 0x06 → 0xFFFFFFFF.
  - Unsigned byte load at 0x07 → 0x00000080.
  - Signed half load at 0x04 → 0x00007F01.
- Byte-store read-modify-write: memory[0x08]=0x11223344, byte store of 0xAA at 0x09 → `MemRead` in cycle 1, `MemWrite` in cycle 2 with `WriteData`=0x1122AA44, `resp_valid` in cycle 3.
- Errors:
  - half load at 0x03 → `resp_valid`+err in cycle 1, no strobe;
  - word store at 0x80 with `MEM_WORDS`=32 → err;
  - size 11 → err.
- Back-to-back: `req_valid` held high for two word loads → second accepted exactly 3 cycles after the first. `MemRead` is low in the cycles between the two pulses.
- Reset mid-operation: `reset` asserted during RD of a half store → no `MemWrite` pulse, `req_ready`=1 after the edge, memory word unchanged.
